inst_prefetch_buffer: RTL and testbench

INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

---
 rtl/ipb_pkg.sv | 23 ++
 rtl/ipb_fifo.sv | 58 +++++
 rtl/inst_prefetch_buffer.sv | 143 ++++++++++++++
 tb/tb_inst_prefetch_buffer.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipb_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package ipb_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        RUN     = 2'd1,
        DISCARD = 2'd2
    } ipb_state_e;

    localparam int IPB_DEPTH_DEFAULT = 4;
    localparam int INSTR_BYTES       = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ipb_entry_t;

    // Sequential fetch address; wraps naturally at the top of the address space.
    function automatic logic [31:0] next_pc(input logic [31:0] pc);
        return pc + 32'(INSTR_BYTES);
    endfunction

endpackage

// File: rtl/ipb_fifo.sv
// Synchronous FIFO of {pc, instr} entries with a flush input.
// Clear wins over push/pop; pop on empty is ignored. Head reads zero when empty.
module ipb_fifo
    import ipb_pkg::*;
#(
    parameter int DEPTH = IPB_DEPTH_DEFAULT
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  ipb_entry_t               push_data_i,
    input  logic                     pop_i,
    output ipb_entry_t               head_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ipb_entry_t        mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              do_push, do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

    // Pointer and occupancy tracking; pointers wrap because DEPTH is a power of two.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;

endmodule

// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer between the instruction cache and the core.
// Optional performance counters are built only when IPB_PERF_CNT_EN is defined.
//
//  state   | meaning
//  BOOT    | load fetch PC from boot_addr, no request
//  RUN     | issue one request at a time while FIFO has room, push responses
//  DISCARD | wait out a pre-redirect request, drop its data
module inst_prefetch_buffer
    import ipb_pkg::*;
#(
    parameter int DEPTH = IPB_DEPTH_DEFAULT
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] boot_addr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_addr,
    output logic [31:0] ic_addr,
    output logic        ic_req,
    input  logic [31:0] ic_data,
    input  logic        ic_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    ipb_state_e    state_q;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   ic_addr_q;
    logic          ic_req_q;

    logic [CW-1:0] count;
    ipb_entry_t    head;
    ipb_entry_t    push_entry;
    logic          fifo_push, fifo_pop, fifo_clear;
    logic          accept;
    logic [CW-1:0] count_after;
    logic [31:0]   pc_after;
    logic          can_issue;

    assign accept      = ic_req_q && ic_ready;
    assign fifo_pop    = if_valid && if_ready;
    assign fifo_clear  = redirect_valid && (state_q != BOOT);
    assign fifo_push   = (state_q == RUN) && accept && !redirect_valid;
    assign push_entry  = '{pc: ic_addr_q, instr: ic_data};
    assign count_after = count + CW'(fifo_push) - CW'(fifo_pop);
    assign pc_after    = fifo_push ? next_pc(fetch_pc_q) : fetch_pc_q;
    assign can_issue   = (count_after < CW'(DEPTH));

    ipb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (HCLK),
        .rst_ni      (HRESETn),
        .clear_i     (fifo_clear),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (head),
        .count_o     (count)
    );

    // Fetch sequencer: request is registered and held until the cache answers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= BOOT;
            fetch_pc_q <= '0;
            ic_req_q   <= 1'b0;
            ic_addr_q  <= '0;
        end else begin
            case (state_q)
                BOOT: begin
                    fetch_pc_q <= boot_addr;
                    ic_req_q   <= 1'b0;
                    state_q    <= RUN;
                end
                RUN: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_addr;
                        if (ic_req_q && !ic_ready) begin
                            // request stays on the bus; its data is dropped later
                            state_q <= DISCARD;
                        end else begin
                            ic_req_q  <= 1'b1;
                            ic_addr_q <= redirect_addr;
                        end
                    end else begin
                        fetch_pc_q <= pc_after;
                        if (!ic_req_q || ic_ready) begin
                            ic_req_q <= can_issue;
                            if (can_issue) ic_addr_q <= pc_after;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect_valid) fetch_pc_q <= redirect_addr;
                    if (ic_ready) begin
                        state_q   <= RUN;
                        ic_req_q  <= 1'b1;
                        ic_addr_q <= redirect_valid ? redirect_addr : fetch_pc_q;
                    end
                end
                default: begin
                    state_q  <= BOOT;
                    ic_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign ic_req   = ic_req_q;
    assign ic_addr  = ic_addr_q;
    assign if_valid = (count != '0);
    assign if_instr = head.instr;
    assign if_pc    = head.pc;

`ifdef IPB_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    // Saturating delivered/starved counters.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (fifo_pop && (perf_fetch_q != 32'hFFFF_FFFF))
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (if_ready && !if_valid && (perf_stall_q != 32'hFFFF_FFFF))
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    assign perf_fetch_cnt = '0;
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Self-checking bench for inst_prefetch_buffer: scoreboard of expected
// deliveries, a table of randomised fetch scenarios, and directed corner cases.
module tb_inst_prefetch_buffer;
    import ipb_pkg::*;

    localparam int DEPTH = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic [31:0] boot_addr = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_addr = '0;
    logic [31:0] ic_addr;
    logic        ic_req;
    logic [31:0] ic_data = '0;
    logic        ic_ready = 1'b0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready = 1'b0;
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;

    always #5 HCLK = ~HCLK;

    inst_prefetch_buffer #(.DEPTH(DEPTH)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .boot_addr      (boot_addr),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .ic_addr        (ic_addr),
        .ic_req         (ic_req),
        .ic_data        (ic_data),
        .ic_ready       (ic_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );

    int          total = 0;
    int          bad = 0;
    ipb_entry_t  sb_q[$];
    logic [31:0] exp_fetch;
    logic        tainted;
    int          cyc, pops, resps;
    logic [31:0] resp_log[$];
    int          first_resp_cyc, first_valid_cyc;
    logic [31:0] first_valid_pc;
    logic        prev_pending;
    logic [31:0] prev_addr;
    logic [31:0] last_pop_pc;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // One clock: score the edge about to happen using current inputs/outputs, then advance.
    task automatic cycle();
        ic_data = instr_of(ic_addr);
        if (if_valid && first_valid_cyc < 0) begin
            first_valid_cyc = cyc;
            first_valid_pc  = if_pc;
        end
        if (prev_pending) begin
            check32("req_held", {31'd0, ic_req}, 32'd1);
            check32("addr_held", ic_addr, prev_addr);
        end
        if (if_valid && if_ready) begin
            pops++;
            last_pop_pc = if_pc;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_pop: got pc %h expected no entry", if_pc);
            end else begin
                ipb_entry_t e;
                e = sb_q.pop_front();
                check32("pop_pc", if_pc, e.pc);
                check32("pop_instr", if_instr, e.instr);
            end
        end
        if (ic_req && ic_ready) begin
            resps++;
            resp_log.push_back(ic_addr);
            if (first_resp_cyc < 0) first_resp_cyc = cyc;
            if (!tainted && !redirect_valid) begin
                ipb_entry_t n;
                check32("fetch_addr", ic_addr, exp_fetch);
                n.pc    = exp_fetch;
                n.instr = instr_of(exp_fetch);
                sb_q.push_back(n);
                exp_fetch = exp_fetch + 32'd4;
                check32("occupancy_le_depth", {31'd0, sb_q.size() <= DEPTH}, 32'd1);
            end
            tainted = 1'b0;
        end
        if (redirect_valid) begin
            sb_q.delete();
            exp_fetch = redirect_addr;
            if (ic_req && !ic_ready) tainted = 1'b1;
        end
        prev_pending = ic_req && !ic_ready;
        prev_addr    = ic_addr;
        @(posedge HCLK);
        #1;
        cyc++;
    endtask

    // Asynchronous reset from a sample point; checks reset values, restarts the model.
    task automatic do_reset(input logic [31:0] boot);
        #2;
        HRESETn = 1'b0;
        #1;
        check32("rst_ic_req", {31'd0, ic_req}, 32'd0);
        check32("rst_ic_addr", ic_addr, 32'd0);
        check32("rst_if_valid", {31'd0, if_valid}, 32'd0);
        check32("rst_if_instr", if_instr, 32'd0);
        check32("rst_if_pc", if_pc, 32'd0);
        check32("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        check32("rst_perf_stall", perf_stall_cnt, 32'd0);
        redirect_valid = 1'b0;
        ic_ready       = 1'b0;
        if_ready       = 1'b0;
        boot_addr      = boot;
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        sb_q.delete();
        resp_log.delete();
        exp_fetch       = boot;
        tainted         = 1'b0;
        prev_pending    = 1'b0;
        pops            = 0;
        resps           = 0;
        cyc             = 0;
        first_resp_cyc  = -1;
        first_valid_cyc = -1;
        first_valid_pc  = '0;
        last_pop_pc     = '0;
    endtask

    typedef struct {
        logic [31:0] boot;
        int          rdy_pct;
        int          ifr_pct;
        int          ncyc;
        int          redir_at;
        logic [31:0] redir_addr;
        logic [31:0] exp_first_pc;
        logic [31:0] exp_redir_pc;
    } vec_t;

    localparam int NV = 5;
    vec_t vecs[NV];

    initial begin
        int p0;
        logic [31:0] first_pc, post_pc;
        logic have_first, have_post, redir_done;

        vecs[0] = '{32'h0000_0100, 100, 100,  30, -1, 32'h0,         32'h0000_0100, 32'h0};
        vecs[1] = '{32'h0000_A000,  70,  60, 120, 60, 32'h0000_B000, 32'h0000_A000, 32'h0000_B000};
        vecs[2] = '{32'hFFFF_FFF0,  80,  90, 100, 50, 32'h0000_0040, 32'hFFFF_FFF0, 32'h0000_0040};
        vecs[3] = '{32'h0001_0000,  50,  30, 150, 70, 32'h0002_0000, 32'h0001_0000, 32'h0002_0000};
        vecs[4] = '{32'h0000_0200, 100, 100,  40, 10, 32'h0000_0300, 32'h0000_0200, 32'h0000_0300};

        // Boot: consecutive addresses, one-cycle response-to-valid latency.
        do_reset(32'h0000_1000);
        ic_ready = 1'b1;
        if_ready = 1'b1;
        for (int k = 0; k < 20; k++) cycle();
        check32("boot_resp_cnt_ge3", {31'd0, resp_log.size() >= 3}, 32'd1);
        if (resp_log.size() >= 3) begin
            check32("boot_addr0", resp_log[0], 32'h0000_1000);
            check32("boot_addr1", resp_log[1], 32'h0000_1004);
            check32("boot_addr2", resp_log[2], 32'h0000_1008);
        end
        check32("boot_latency", 32'(first_valid_cyc), 32'(first_resp_cyc + 1));
        check32("boot_first_pc", first_valid_pc, 32'h0000_1000);

        // Backpressure: fill exactly DEPTH, then one pop reopens requests.
        do_reset(32'h0000_2000);
        ic_ready = 1'b1;
        if_ready = 1'b0;
        for (int k = 0; k < 12; k++) cycle();
        check32("bp_fill", 32'(resps), 32'd4);
        check32("bp_req_low", {31'd0, ic_req}, 32'd0);
        check32("bp_valid", {31'd0, if_valid}, 32'd1);
        if_ready = 1'b1;
        cycle();
        if_ready = 1'b0;
        check32("bp_req_after_pop", {31'd0, ic_req}, 32'd1);
        check32("bp_addr_after_pop", ic_addr, 32'h0000_2010);
        if_ready = 1'b1;
        for (int k = 0; k < 10; k++) cycle();

        // Redirect while a request is outstanding: data dropped, refetch from target.
        do_reset(32'h0000_2000);
        ic_ready = 1'b1;
        if_ready = 1'b1;
        for (int k = 0; k < 40 && !(ic_req && ic_addr == 32'h0000_2008); k++) cycle();
        check32("mf_reach_2008", {31'd0, ic_req && ic_addr == 32'h0000_2008}, 32'd1);
        ic_ready = 1'b0;
        cycle();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_4000;
        cycle();
        redirect_valid = 1'b0;
        check32("mf_fifo_empty", {31'd0, if_valid}, 32'd0);
        check32("mf_addr_held", ic_addr, 32'h0000_2008);
        cycle();
        cycle();
        ic_ready = 1'b1;
        cycle();
        ic_ready = 1'b0;
        check32("mf_next_req", {31'd0, ic_req}, 32'd1);
        check32("mf_next_addr", ic_addr, 32'h0000_4000);
        check32("mf_no_stale", {31'd0, if_valid}, 32'd0);
        ic_ready = 1'b1;
        p0 = pops;
        for (int k = 0; k < 20 && pops == p0; k++) cycle();
        check32("mf_first_pc", last_pop_pc, 32'h0000_4000);

        // Redirect coinciding with the response: no discard phase.
        do_reset(32'h0000_3000);
        ic_ready = 1'b0;
        if_ready = 1'b1;
        for (int k = 0; k < 20 && !ic_req; k++) cycle();
        check32("co_req_addr", ic_addr, 32'h0000_3000);
        ic_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_5000;
        cycle();
        redirect_valid = 1'b0;
        ic_ready       = 1'b0;
        check32("co_next_req", {31'd0, ic_req}, 32'd1);
        check32("co_next_addr", ic_addr, 32'h0000_5000);
        check32("co_no_stale", {31'd0, if_valid}, 32'd0);
        ic_ready = 1'b1;
        p0 = pops;
        for (int k = 0; k < 20 && pops == p0; k++) cycle();
        check32("co_first_pc", last_pop_pc, 32'h0000_5000);

        // Address wrap, then reset in the middle of a request.
        do_reset(32'hFFFF_FFFC);
        ic_ready = 1'b1;
        if_ready = 1'b1;
        for (int k = 0; k < 20 && resps < 2; k++) cycle();
        check32("wrap_resp_cnt", 32'(resps), 32'd2);
        if (resp_log.size() >= 2) begin
            check32("wrap_addr0", resp_log[0], 32'hFFFF_FFFC);
            check32("wrap_addr1", resp_log[1], 32'h0000_0000);
        end
        ic_ready = 1'b0;
        for (int k = 0; k < 20 && !ic_req; k++) cycle();
        cycle();
        check32("midreq_pending", {31'd0, ic_req}, 32'd1);
        do_reset(32'h0000_7000);
        ic_ready = 1'b1;
        for (int k = 0; k < 20 && resps < 1; k++) cycle();
        check32("rst_refetch_addr", (resp_log.size() > 0) ? resp_log[0] : 32'hDEAD_BEEF, 32'h0000_7000);

        // Performance counters: 10 deliveries, then 3 starved cycles.
        do_reset(32'h0000_8000);
        ic_ready = 1'b1;
        if_ready = 1'b0;
        for (int k = 0; k < 20 && !if_valid; k++) cycle();
        p0 = pops;
        for (int k = 0; k < 100 && (pops - p0) < 10; k++) begin
            if_ready = 1'b1;
            cycle();
        end
        if_ready       = 1'b0;
        ic_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_addr  = 32'h0000_9000;
        cycle();
        redirect_valid = 1'b0;
        if_ready = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        if_ready = 1'b0;
`ifdef IPB_PERF_CNT_EN
        check32("perf_fetch", perf_fetch_cnt, 32'd10);
        check32("perf_stall", perf_stall_cnt, 32'd3);
`else
        check32("perf_fetch_off", perf_fetch_cnt, 32'd0);
        check32("perf_stall_off", perf_stall_cnt, 32'd0);
`endif

        // Table-driven randomised scenarios, scoreboard checks every delivery.
        for (int r = 0; r < NV; r++) begin
            do_reset(vecs[r].boot);
            have_first = 1'b0;
            have_post  = 1'b0;
            redir_done = 1'b0;
            first_pc   = 32'hDEAD_BEEF;
            post_pc    = 32'hDEAD_BEEF;
            for (int c = 0; c < vecs[r].ncyc; c++) begin
                ic_ready       = ($urandom_range(0, 99) < vecs[r].rdy_pct);
                if_ready       = ($urandom_range(0, 99) < vecs[r].ifr_pct);
                redirect_valid = (c == vecs[r].redir_at);
                redirect_addr  = vecs[r].redir_addr;
                p0 = pops;
                cycle();
                if (pops != p0) begin
                    if (!have_first) begin
                        have_first = 1'b1;
                        first_pc   = last_pop_pc;
                    end
                    if (redir_done && !have_post) begin
                        have_post = 1'b1;
                        post_pc   = last_pop_pc;
                    end
                end
                if (c == vecs[r].redir_at) redir_done = 1'b1;
            end
            redirect_valid = 1'b0;
            check32($sformatf("vec%0d_first_pc", r), first_pc, vecs[r].exp_first_pc);
            if (vecs[r].redir_at >= 0)
                check32($sformatf("vec%0d_redir_pc", r), post_pc, vecs[r].exp_redir_pc);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule
